// File: rtl/maxpool_stream_if.sv
// Streaming pixel bus for maxpool_stream: input beats in, pooled pixels out,
// both with valid/ready handshakes.
interface maxpool_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;
  logic                           out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool_stream.sv
// 2x2 stride-2 signed max pooling over a row-major pixel stream, per channel.
// Define MAXPOOL_STREAM_RELU_EN to clamp negative pooled results to zero.
module maxpool_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int MAX_WIDTH  = 32,
  parameter int MAX_HEIGHT = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]    cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]   cfg_height,
  maxpool_stream_if.slave                   bus
);
  localparam int PW       = CHANNELS * DATA_WIDTH;
  localparam int CW       = $clog2(MAX_WIDTH + 1);
  localparam int RW       = $clog2(MAX_HEIGHT + 1);
  localparam int LB_DEPTH = MAX_WIDTH / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef logic [PW-1:0] pix_t;

  function automatic pix_t vmax(input pix_t a, input pix_t b);
    pix_t r;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] y;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      x = a[c*DATA_WIDTH +: DATA_WIDTH];
      y = b[c*DATA_WIDTH +: DATA_WIDTH];
      r[c*DATA_WIDTH +: DATA_WIDTH] = (x > y) ? x : y;
    end
    return r;
  endfunction

`ifdef MAXPOOL_STREAM_RELU_EN
  function automatic pix_t relu(input pix_t a);
    pix_t r;
    r = a;
    for (int c = 0; c < CHANNELS; c++) begin
      if (a[c*DATA_WIDTH + DATA_WIDTH - 1]) r[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction
`endif

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_w;
  logic [RW-1:0] r_h;
  pix_t          r_hold;
  pix_t          r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  pix_t          r_lb [0:LB_DEPTH-1];

  logic          w_accept;
  logic          w_first;
  logic [CW-1:0] w_w;
  logic [RW-1:0] w_h;
  logic          w_col_end;
  logic          w_row_end;
  logic          w_frame_ok;
  logic          w_in_win;
  logic          w_do;
  logic          w_load;
  logic          w_last;
  logic [LBW-1:0] w_lb_idx;
  pix_t          w_lb_rd;
  pix_t          w_max_hold;
  pix_t          w_max_lb;
  pix_t          w_result;

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_first  = (r_col == '0) && (r_row == '0);

  // The frame-start beat already obeys the geometry it latches.
  assign w_w = w_first ? cfg_width  : r_w;
  assign w_h = w_first ? cfg_height : r_h;

  assign w_col_end = ((CW+1)'(r_col) + (CW+1)'(1)) >= (CW+1)'(w_w);
  assign w_row_end = ((RW+1)'(r_row) + (RW+1)'(1)) >= (RW+1)'(w_h);

  assign w_frame_ok = (w_w >= CW'(2)) && (w_w <= CW'(MAX_WIDTH)) &&
                      (w_h >= RW'(2)) && (w_h <= RW'(MAX_HEIGHT));

  // Floor semantics: an odd trailing column/row never falls inside a window.
  assign w_in_win = (r_col[CW-1:1] < w_w[CW-1:1]) && (r_row[RW-1:1] < w_h[RW-1:1]);
  assign w_do     = w_accept && w_frame_ok && w_in_win;
  assign w_load   = w_do && r_row[0] && r_col[0];

  assign w_last = (r_row[RW-1:1] == (w_h[RW-1:1] - (RW-1)'(1))) &&
                  (r_col[CW-1:1] == (w_w[CW-1:1] - (CW-1)'(1)));

  assign w_lb_idx   = LBW'(r_col >> 1);
  assign w_lb_rd    = r_lb[w_lb_idx];
  assign w_max_hold = vmax(r_hold, bus.in_data);
  assign w_max_lb   = vmax(w_lb_rd, bus.in_data);

`ifdef MAXPOOL_STREAM_RELU_EN
  assign w_result = relu(w_max_hold);
`else
  assign w_result = w_max_hold;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_first) begin
          r_w <= cfg_width;
          r_h <= cfg_height;
        end
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      if (w_do && !r_col[0]) begin
        r_hold <= r_row[0] ? w_max_lb : bus.in_data;
      end

      // Load and drain may coincide; the load wins and keeps valid high.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_last  <= w_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Line buffer holds top-row pair maxima; every entry is rewritten on an
  // even row before the odd row reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_do && !r_row[0] && r_col[0]) begin
      r_lb[w_lb_idx] <= w_max_hold;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: directed vector table, multi-cycle
// corner sequences and randomized frames against a frame-level pooling model.
module tb_maxpool_stream;
  localparam int DW = 8;
  localparam int CH = 4;
  localparam int MW = 32;
  localparam int MH = 32;
  localparam int PW = CH * DW;
  localparam int CW = $clog2(MW + 1);
  localparam int RW = $clog2(MH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] cfg_w;
  logic [RW-1:0] cfg_h;

  maxpool_stream_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  maxpool_stream #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_width(cfg_w), .cfg_height(cfg_h), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          last;
  } out_t;

  typedef struct packed {
    logic [3:0][PW-1:0] px;
    logic [PW-1:0]      exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  bit   bp_en = 0;
  out_t got_q[$];
  out_t exp_q[$];
  logic [PW-1:0] frame_px[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        out_t o;
        o.data = bus.out_data;
        o.last = bus.out_last;
        got_q.push_back(o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary follows");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] rep(input int v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
    return {CH{b}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [PW-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      step();
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_exp(input int v, input bit last);
    out_t o;
    o.data = rep(v);
    o.last = last;
    exp_q.push_back(o);
  endtask

  task automatic check_q(input string name);
    int k;
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      out_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_data%0d", name, k), 64'(g.data), 64'(e.data));
      chk($sformatf("%s_last%0d", name, k), 64'(g.last), 64'(e.last));
      k++;
    end
    chk($sformatf("%s_leftover(got+exp)", name), 64'(got_q.size() + exp_q.size()), 64'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Frame-level reference: pool the whole stored frame at once.
  task automatic model_frame(input int w, input int h);
    if (w < 2 || w > MW || h < 2 || h > MH) return;
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        out_t o;
        o.data = '0;
        for (int l = 0; l < CH; l++) begin
          int m;
          m = -1000;
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              logic [PW-1:0] p;
              int v;
              p = frame_px[(2*pr + dr) * w + 2*pc + dc];
              v = $signed(p[l*DW +: DW]);
              if (v > m) m = v;
            end
          end
`ifdef MAXPOOL_STREAM_RELU_EN
          if (m < 0) m = 0;
`endif
          o.data[l*DW +: DW] = m[DW-1:0];
        end
        o.last = (pr == h/2 - 1) && (pc == w/2 - 1);
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic send_ramp(input int n);
    for (int i = 0; i < n; i++) send(rep(i));
  endtask

  vec_t tbl[5];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    cfg_w = CW'(4);
    cfg_h = RW'(4);

    tbl[0].px = {32'hFEFEFEFE, 32'hF9F9F9F9, 32'hFFFFFFFF, 32'hFDFDFDFD};
`ifdef MAXPOOL_STREAM_RELU_EN
    tbl[0].exp = 32'h00000000;
`else
    tbl[0].exp = 32'hFFFFFFFF;
`endif
    tbl[1].px  = {32'h460A0B0C, 32'h073C0809, 32'h04053206, 32'h01020328};
    tbl[1].exp = 32'h463C3228;
    tbl[2].px  = {32'hFFFFFFFF, 32'h00000000, 32'h7F7F7F7F, 32'h80808080};
    tbl[2].exp = 32'h7F7F7F7F;
    tbl[3].px  = {32'hFF810281, 32'h90800080, 32'h8100FFFE, 32'h807F01FF};
`ifdef MAXPOOL_STREAM_RELU_EN
    tbl[3].exp = 32'h007F0200;
    tbl[4].exp = 32'h00000000;
`else
    tbl[3].exp = 32'hFF7F02FF;
    tbl[4].exp = 32'h80808080;
`endif
    tbl[4].px  = {32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080};

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single-window vector table on 2x2 frames
    cfg_w = CW'(2);
    cfg_h = RW'(2);
    for (int t = 0; t < 5; t++) begin
      for (int p = 0; p < 4; p++) send(tbl[t].px[p]);
      chk($sformatf("tbl%0d_valid", t), 64'(bus.out_valid), 64'd1);
      chk($sformatf("tbl%0d_data", t), 64'(bus.out_data), 64'(tbl[t].exp));
      chk($sformatf("tbl%0d_last", t), 64'(bus.out_last), 64'd1);
      step();
    end
    got_q.delete();

    // 4x4 ramp, latency of one cycle after each window-completing beat
    cfg_w = CW'(4);
    cfg_h = RW'(4);
    for (int i = 0; i < 16; i++) begin
      bit hit;
      send(rep(i));
      hit = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      chk($sformatf("lat_valid_b%0d", i), 64'(bus.out_valid), 64'(hit));
      if (hit) begin
        chk($sformatf("lat_data_b%0d", i), 64'(bus.out_data), 64'(rep(i)));
        chk($sformatf("lat_last_b%0d", i), 64'(bus.out_last), 64'(i == 15));
      end
    end
    step();
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_q("ramp4x4");

    // Backpressure: stall five cycles on the first output
    send_ramp(6);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = rep(6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready_c%0d", c), 64'(bus.in_ready), 64'd0);
      chk($sformatf("stall_valid_c%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall_data_c%0d", c), 64'(bus.out_data), 64'(rep(5)));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 6; i < 16; i++) send(rep(i));
    step();
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_q("stall");

    // Odd 5x3 frame then a clean 4x4 frame
    cfg_w = CW'(5);
    cfg_h = RW'(3);
    send_ramp(15);
    cfg_w = CW'(4);
    cfg_h = RW'(4);
    send_ramp(16);
    step();
    push_exp(6, 0); push_exp(8, 1);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_q("odd5x3");

    // Reset in the middle of a frame
    send_ramp(6);
    chk("midrst_pre_valid", 64'(bus.out_valid), 64'd1);
    chk("midrst_pre_data", 64'(bus.out_data), 64'(rep(5)));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_data", 64'(bus.out_data), 64'd0);
    chk("midrst_last", 64'(bus.out_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_ramp(16);
    step();
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    check_q("midrst");

    // Randomized frames with gaps, backpressure and mid-frame cfg changes
    bp_en = 1;
    for (int f = 0; f < 25; f++) begin
      int w, h;
      w = ($urandom_range(0, 9) == 0) ? 34 : int'($urandom_range(1, 12));
      h = ($urandom_range(0, 11) == 0) ? 33 : int'($urandom_range(1, 7));
      if (w == 34 && h == 33) h = 3;
      frame_px.delete();
      for (int b = 0; b < w * h; b++) frame_px.push_back(PW'($urandom));
      model_frame(w, h);
      cfg_w = CW'(w);
      cfg_h = RW'(h);
      for (int b = 0; b < w * h; b++) begin
        if ($urandom_range(0, 3) == 0) step();
        send(frame_px[b]);
        if (b == 0) begin
          cfg_w = CW'($urandom);
          cfg_h = RW'($urandom);
        end
      end
    end
    bp_en = 0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check_q("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 Parameter DATA_WIDTH, 8, bits per channel element, signed two's complement.
REQ-002 Parameter CHANNELS, 4, channel elements packed per beat, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-003 Parameter MAX_WIDTH, 32, largest supported frame width in pixels, even, >=2.
REQ-004 Parameter MAX_HEIGHT, 32, largest supported frame height in pixels, >=2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cfg_width  input  $clog2(MAX_WIDTH+1)  frame width in pixels.
REQ-008 cfg_height  input  $clog2(MAX_HEIGHT+1)  frame height in pixels.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-011 in_data  input  CHANNELS*DATA_WIDTH  one pixel, all channels, row-major order.
REQ-012 out_valid  output  1  pooled pixel valid.
REQ-013 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-014 out_data  output  CHANNELS*DATA_WIDTH  pooled pixel, same packing.
REQ-015 out_last  output  1  high with the final pooled pixel of a frame.

Function
REQ-016 Block SHALL compute 2x2, stride-2 max pooling per channel, independently, signed comparison.
REQ-017 Counters col (0..W-1) and row (0..H-1) SHALL advance on each accepted beat; col wraps to 0 and row increments at col==W-1; both wrap to 0 after (W-1,H-1).
REQ-018 cfg_width/cfg_height SHALL be latched into W/H on the accepted beat at (row,col)==(0,0); changes mid-frame have no effect.
REQ-019 Even row, even col: hold register <= in; even row, odd col: linebuf[col>>1] <= max(hold,in).
REQ-020 Odd row, even col: hold <= max(linebuf[col>>1],in); odd row, odd col: result = max(hold,in) loaded into output register.
REQ-021 Trailing column when W odd and trailing row when H odd SHALL be accepted and discarded (floor semantics); no output generated.
REQ-022 If latched W<2, W>MAX_WIDTH, H<2 or H>MAX_HEIGHT, all beats of that frame SHALL be accepted and discarded.
REQ-023 Output register: out_valid SHALL rise the cycle after the beat completing a window is accepted (latency 1) and hold, with stable out_data/out_last, until out_valid && out_ready.
REQ-024 in_ready SHALL equal !out_valid || out_ready (combinational); simultaneous drain and load in one cycle allowed, no bubble.
REQ-025 out_last SHALL be 1 only for the window at pooled row (H/2)-1, pooled column (W/2)-1.
REQ-026 Line buffer depth MAX_WIDTH/2, width CHANNELS*DATA_WIDTH; entries SHALL be written before read in every frame.

Reset
REQ-027 On rst_n low: out_valid=0, out_data=0, out_last=0, row=col=0, hold=0, W/H latches=0; in_ready=1 after deassert.
REQ-028 Reset mid-frame SHALL abort the frame; next accepted beat is (0,0) of a new frame; line buffer need not be cleared.

Configuration
REQ-029 Macro MAXPOOL_STREAM_RELU_EN defined: each channel result SHALL be replaced by 0 when negative (fused ReLU) before the output register.
REQ-030 Macro undefined: results SHALL pass unmodified, negatives included; no other behaviour differs.

Verification
REQ-031 4x4, CHANNELS=1, pixels 0..15 row-major, out_ready=1 -> outputs 5,7,13,15; out_last only on 15; each 1 cycle after beats 5,7,13,15.
REQ-032 Same frame, out_ready low 5 cycles when first output valid -> out_data held 5, in_ready=0 throughout, no beat lost, sequence unchanged.
REQ-033 5x3 frame, values 0..14 -> outputs 6,8 only; out_last on 8; next frame starts cleanly at (0,0).
REQ-034 2x2 window -3,-1,-7,-2 -> out 0xFF (-1) without MAXPOOL_STREAM_RELU_EN, 0x00 with it.
REQ-035 CHANNELS=4, per-channel distinct maxima in different pixels -> each lane carries its own channel max.
REQ-036 rst_n pulsed low after 6 beats of a 4x4 frame -> outputs 0 at once; new full frame yields 5,7,13,15 exactly.
